hall_sector_decoder: RTL and testbench
======================================

Name: hall_sector_decoder

Overview:
Upstream conditioning stage for the BLDC commutation logic. Takes the three raw hall sensor inputs and synchronises and debounces them. Decodes the result into a validated 0..5 rotor sector with a one-cycle commutation strobe, direction, and measured sector period. The commutation/PWM stage downstream consumes SECTOR and COMM_STB instead of raw H1..H3.

Parameters:
DEB_CYCLES, 4, consecutive CLK cycles a synchronised hall code must be stable before acceptance (>=1)
PW, 16, width of sector-period counter/output

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
H1  in  1  raw hall sensor 1 (asynchronous)
H2  in  1  raw hall sensor 2 (asynchronous)
H3  in  1  raw hall sensor 3 (asynchronous)
SECTOR  out  3  accepted rotor sector 0..5
SECTOR_VALID  out  1  a valid sector has been accepted since reset
COMM_STB  out  1  one-cycle pulse on every accepted sector change
DIR  out  1  1 = forward (sector+1), 0 = reverse (sector-1)
PERIOD  out  PW  CLK cycles between last two adjacent-step strobes
PERIOD_VALID  out  1  PERIOD is meaningful
SEQ_ERR  out  1  one-cycle pulse on a non-adjacent sector jump
HALL_FAULT  out  1  debounced code is 000 or 111
STALL  out  1  no accepted change for 2^PW-1 cycles

Behaviour:
- Clocking: one clock, CLK. RST is synchronous and active-high. Every register is cleared on the CLK edge while RST=1.
- Reset values: SECTOR=0, SECTOR_VALID=0, COMM_STB=0, DIR=1, PERIOD=0, PERIOD_VALID=0, SEQ_ERR=0, HALL_FAULT=0, STALL=0. Synchroniser and debounce state are cleared.
- Sync: {H1,H2,H3} passes through a 2-FF synchroniser per bit.
- Debounce: a stable counter resets whenever the synchronised code differs from its previous-cycle value. The code is "debounced" once it has been stable DEB_CYCLES cycles.
- Latency: from the first CLK edge sampling a new stable raw code to the COMM_STB=1 cycle is exactly DEB_CYCLES+3 edges. A raw glitch shorter than DEB_CYCLES+1 cycles produces no output change.
- Decode ({H1,H2,H3} -> sector): 100->0, 101->1, 001->2, 011->3, 010->4, 110->5. Codes 000 and 111 are invalid.
- Invalid debounced code: HALL_FAULT=1. SECTOR, DIR and PERIOD hold, with no COMM_STB. HALL_FAULT clears in the cycle the next valid code is accepted.
- Accepted valid code equal to the current SECTOR with SECTOR_VALID=1 (e.g. return after a fault): no strobe.
- Accepted valid code otherwise, classified as one of:
  - First acquisition (SECTOR_VALID=0): SECTOR loads, SECTOR_VALID=1, COMM_STB pulses. DIR and PERIOD_VALID are unchanged.
  - Adjacent step (+1 or -1 mod 6): SECTOR loads, COMM_STB pulses, DIR=1 for +1 and 0 for -1. If STALL=0, PERIOD loads the cycle count and PERIOD_VALID=1.
  - Non-adjacent jump (+/-2, 3): SECTOR loads, COMM_STB and SEQ_ERR pulse together. DIR holds and PERIOD_VALID=0.
- Period counter:
  - Restarts on every COMM_STB, such that strobes N cycles apart yield PERIOD=N.
  - Saturates at 2^PW-1. On reaching saturation STALL=1 and PERIOD_VALID=0.
  - STALL clears on the next COMM_STB; that strobe does not load PERIOD.
- RST mid-rotation returns to the reset state. The next accepted code is treated as first acquisition.
- All outputs are registered; no combinational input-to-output path.

Decomposition:
- Shared package bldc_pkg holds:
  - sector encoding localparams SEC0..SEC5;
  - hall-code-to-sector map function;
  - sector_step function returning +1/-1/other;
  - NUM_SECTORS=6.
- One sub-module: hall_debounce, covering the 3-bit 2-FF sync plus stable counter, with a debounced code and update pulse out. The decoder FSM, direction and period logic stay in the top.

Test Plan:
- Forward rotation: CLK 40 ns, DEB_CYCLES=4. Codes 100,101,001,011,010,110 repeated, 1000 ns each -> SECTOR 0,1,2,3,4,5,0. COMM_STB every 25 cycles. DIR=1. PERIOD=25 with PERIOD_VALID=1 from the second strobe on.
- Reverse rotation: same codes in reverse order -> SECTOR steps down, DIR=0 after the first step, PERIOD=25.
- Glitch rejection: at SECTOR=2, pulse H2 high for 3 cycles -> no COMM_STB and SECTOR stays 2. Hold the change for 5 cycles -> SECTOR=3 exactly DEB_CYCLES+3=7 edges after first sampling.
- Fault: force 000 and hold -> HALL_FAULT=1 with SECTOR held. Restore 001 (same sector) -> HALL_FAULT=0 and no strobe. Restore 011 -> SECTOR=3 with strobe.
- Jump/stall: from sector 0 apply 001 -> SECTOR=2, SEQ_ERR and COMM_STB pulse together, PERIOD_VALID=0. With PW=6, hold a code 63 cycles -> STALL=1. Next step clears STALL and PERIOD_VALID stays 0.
- Reset mid-rotation: assert RST for 1 cycle at sector 4 -> all outputs at reset values. The next accepted code gives SECTOR_VALID=1, COMM_STB, and DIR=1 unchanged.

Source files
------------

// File: rtl/bldc_pkg.sv
// Shared BLDC definitions: sector encoding, hall-code decode and sector-step classification.
package bldc_pkg;

  localparam int NUM_SECTORS = 6;

  localparam logic [2:0] SEC0     = 3'd0;
  localparam logic [2:0] SEC1     = 3'd1;
  localparam logic [2:0] SEC2     = 3'd2;
  localparam logic [2:0] SEC3     = 3'd3;
  localparam logic [2:0] SEC4     = 3'd4;
  localparam logic [2:0] SEC5     = 3'd5;
  localparam logic [2:0] SEC_NONE = 3'd7;

  typedef enum logic [1:0] {
    STEP_SAME,
    STEP_FWD,
    STEP_REV,
    STEP_JUMP
  } step_e;

  typedef enum logic [1:0] {
    ST_ACQUIRE,
    ST_RUN,
    ST_FAULT
  } dec_state_e;

  // {H1,H2,H3} -> sector; 000 and 111 map to SEC_NONE.
  function automatic logic [2:0] hall_to_sector(input logic [2:0] code);
    case (code)
      3'b100:  hall_to_sector = SEC0;
      3'b101:  hall_to_sector = SEC1;
      3'b001:  hall_to_sector = SEC2;
      3'b011:  hall_to_sector = SEC3;
      3'b010:  hall_to_sector = SEC4;
      3'b110:  hall_to_sector = SEC5;
      default: hall_to_sector = SEC_NONE;
    endcase
  endfunction

  function automatic step_e sector_step(input logic [2:0] from, input logic [2:0] to);
    logic [2:0] nxt;
    logic [2:0] prv;
    nxt = (from == 3'(NUM_SECTORS - 1)) ? SEC0 : from + 3'd1;
    prv = (from == SEC0) ? 3'(NUM_SECTORS - 1) : from - 3'd1;
    if (to == from)     sector_step = STEP_SAME;
    else if (to == nxt) sector_step = STEP_FWD;
    else if (to == prv) sector_step = STEP_REV;
    else                sector_step = STEP_JUMP;
  endfunction

endpackage

// File: rtl/hall_debounce.sv
// Two-flop synchroniser for the 3-bit hall code plus a stability counter that
// emits a one-cycle update pulse when a newly settled code has been stable long enough.
module hall_debounce
  import bldc_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] hall,
  output logic [2:0] code,
  output logic       upd
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [2:0]    sync1_q;
  logic [2:0]    sync2_q;
  logic [2:0]    prev_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      prev_q  <= 3'b000;
      cnt_q   <= '0;
    end else begin
      sync1_q <= hall;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (sync2_q != prev_q)
        cnt_q <= '0;
      else if (cnt_q != CW'(DEB_CYCLES))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires on the cycle the counter would reach DEB_CYCLES, so the consumer's
  // registered outputs change on that same edge.
  assign code = sync2_q;
  assign upd  = (sync2_q == prev_q) && (cnt_q == CW'(DEB_CYCLES - 1));

endmodule

// File: rtl/hall_sector_decoder.sv
// Hall sensor conditioning: debounced code -> validated rotor sector with commutation
// strobe, direction, sector period measurement and fault/stall flags.
module hall_sector_decoder
  import bldc_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int PW         = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          H1,
  input  logic          H2,
  input  logic          H3,
  output logic [2:0]    SECTOR,
  output logic          SECTOR_VALID,
  output logic          COMM_STB,
  output logic          DIR,
  output logic [PW-1:0] PERIOD,
  output logic          PERIOD_VALID,
  output logic          SEQ_ERR,
  output logic          HALL_FAULT,
  output logic          STALL
);

  localparam logic [PW-1:0] PMAX = {PW{1'b1}};

  logic [2:0]    deb_code;
  logic          deb_upd;
  logic [2:0]    new_sec;
  step_e         step;

  dec_state_e    state_q, state_d;
  logic [2:0]    sector_q, sector_d;
  logic          valid_q, valid_d;
  logic          stb_q, stb_d;
  logic          dir_q, dir_d;
  logic [PW-1:0] period_q, period_d;
  logic          pvalid_q, pvalid_d;
  logic          seq_q, seq_d;
  logic          fault_q, fault_d;
  logic          stall_q, stall_d;
  logic [PW-1:0] pcnt_q, pcnt_d;

  hall_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk  (CLK),
    .rst  (RST),
    .hall ({H1, H2, H3}),
    .code (deb_code),
    .upd  (deb_upd)
  );

  assign new_sec = hall_to_sector(deb_code);
  assign step    = sector_step(sector_q, new_sec);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_ACQUIRE;
      sector_q <= SEC0;
      valid_q  <= 1'b0;
      stb_q    <= 1'b0;
      dir_q    <= 1'b1;
      period_q <= '0;
      pvalid_q <= 1'b0;
      seq_q    <= 1'b0;
      fault_q  <= 1'b0;
      stall_q  <= 1'b0;
      pcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      sector_q <= sector_d;
      valid_q  <= valid_d;
      stb_q    <= stb_d;
      dir_q    <= dir_d;
      period_q <= period_d;
      pvalid_q <= pvalid_d;
      seq_q    <= seq_d;
      fault_q  <= fault_d;
      stall_q  <= stall_d;
      pcnt_q   <= pcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sector_d = sector_q;
    valid_d  = valid_q;
    stb_d    = 1'b0;
    dir_d    = dir_q;
    period_d = period_q;
    pvalid_d = pvalid_q;
    seq_d    = 1'b0;
    fault_d  = fault_q;
    stall_d  = stall_q;
    pcnt_d   = pcnt_q;

    if (deb_upd) begin
      if (new_sec == SEC_NONE) begin
        fault_d = 1'b1;
        if (state_q == ST_RUN) state_d = ST_FAULT;
      end else begin
        fault_d = 1'b0;
        state_d = ST_RUN;
        if (!valid_q) begin
          sector_d = new_sec;
          valid_d  = 1'b1;
          stb_d    = 1'b1;
        end else begin
          case (step)
            STEP_SAME: ;
            STEP_FWD, STEP_REV: begin
              sector_d = new_sec;
              stb_d    = 1'b1;
              dir_d    = (step == STEP_FWD);
              // A step ending a stall has no meaningful interval to report.
              if (!stall_q) begin
                period_d = pcnt_q;
                pvalid_d = 1'b1;
              end
            end
            default: begin
              sector_d = new_sec;
              stb_d    = 1'b1;
              seq_d    = 1'b1;
              pvalid_d = 1'b0;
            end
          endcase
        end
      end
    end

    // Counter value 1 right after a strobe makes strobes N cycles apart read N.
    if (stb_d) begin
      pcnt_d  = PW'(1);
      stall_d = 1'b0;
    end else begin
      if (pcnt_q != PMAX) pcnt_d = pcnt_q + 1'b1;
      if (pcnt_d == PMAX) begin
        stall_d  = 1'b1;
        pvalid_d = 1'b0;
      end
    end
  end

  // COMM_STB and SEQ_ERR are single-cycle strobes with no back-pressure; the
  // consumer must sample them on the cycle they are high.
  assign SECTOR       = sector_q;
  assign SECTOR_VALID = valid_q;
  assign COMM_STB     = stb_q;
  assign DIR          = dir_q;
  assign PERIOD       = period_q;
  assign PERIOD_VALID = pvalid_q;
  assign SEQ_ERR      = seq_q;
  assign HALL_FAULT   = fault_q;
  assign STALL        = stall_q;

endmodule

// File: tb/tb_hall_sector_decoder.sv
// Bench for hall_sector_decoder: directed rotation/glitch/fault/jump/stall/reset
// scenarios plus random hall codes, checked every cycle against a sample-history model.
module tb_hall_sector_decoder;

  localparam int DEB = 4;
  localparam int PW  = 6;
  localparam int MAX = 63;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          h1 = 1'b1, h2 = 1'b0, h3 = 1'b0;
  logic [2:0]    sector;
  logic          sector_valid, comm_stb, dir, period_valid, seq_err, hall_fault, stall;
  logic [PW-1:0] period;

  hall_sector_decoder #(.DEB_CYCLES(DEB), .PW(PW)) dut (
    .CLK          (clk),
    .RST          (rst),
    .H1           (h1),
    .H2           (h2),
    .H3           (h3),
    .SECTOR       (sector),
    .SECTOR_VALID (sector_valid),
    .COMM_STB     (comm_stb),
    .DIR          (dir),
    .PERIOD       (period),
    .PERIOD_VALID (period_valid),
    .SEQ_ERR      (seq_err),
    .HALL_FAULT   (hall_fault),
    .STALL        (stall)
  );

  // ---------------- clock / watchdog ----------------
  always #20 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int stb_seen = 0, seq_seen = 0, both_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Sector lookup indexed by {H1,H2,H3}; -1 marks an invalid code.
  int dec_tab[8] = '{-1, 2, 4, 3, 0, 1, 5, -1};

  logic [2:0] smp[$];
  logic [2:0] exp_q[$];
  int  ecnt = 0;
  int  rst_edge = 0;
  bit  model_on = 0;
  int  m_sector, m_valid, m_stb, m_dir, m_period, m_pvalid, m_seq, m_fault, m_stall, m_age;

  always @(posedge clk) begin : model_blk
    int n, sec, diff, age_before;
    bit acc, stall_before;
    logic [2:0] code;
    ecnt++;
    smp.push_back(rst ? 3'b000 : {h1, h2, h3});
    if (smp.size() > 12) void'(smp.pop_front());
    n = smp.size();
    if (rst) begin
      // The cleared synchroniser looks like three 000 samples.
      if (n >= 3) begin
        smp[n-2] = 3'b000;
        smp[n-3] = 3'b000;
      end
      rst_edge = ecnt;
      model_on = 1;
      m_sector = 0; m_valid = 0; m_stb = 0; m_dir = 1; m_period = 0;
      m_pvalid = 0; m_seq = 0; m_fault = 0; m_stall = 0; m_age = 0;
      exp_q.delete();
    end else if (model_on) begin
      m_stb = 0;
      m_seq = 0;
      age_before   = m_age;
      stall_before = (m_age == MAX);
      // Accept at edge e when the code first sampled at edge e-DEB-2 has been
      // sampled unchanged for DEB+1 edges.
      acc = 0;
      if ((ecnt - rst_edge) >= DEB + 3 && n >= DEB + 4) begin
        acc = 1;
        for (int j = 2; j <= DEB + 2; j++)
          if (smp[n-1-j] != smp[n-1-(DEB+2)]) acc = 0;
        if (smp[n-1-(DEB+3)] == smp[n-1-(DEB+2)]) acc = 0;
      end
      if (acc) begin
        code = smp[n-3];
        sec  = dec_tab[code];
        if (sec < 0) begin
          m_fault = 1;
        end else begin
          m_fault = 0;
          if (m_valid == 0) begin
            m_sector = sec; m_valid = 1; m_stb = 1;
          end else if (sec != m_sector) begin
            diff  = (sec - m_sector + 6) % 6;
            m_stb = 1;
            if (diff == 1 || diff == 5) begin
              m_dir = (diff == 1);
              if (!stall_before) begin
                m_period = age_before;
                m_pvalid = 1;
              end
            end else begin
              m_seq    = 1;
              m_pvalid = 0;
            end
            m_sector = sec;
          end
        end
      end
      if (m_stb) begin
        m_age = 1;
        exp_q.push_back(3'(m_sector));
      end else begin
        if (m_age < MAX) m_age++;
        if (m_age == MAX) m_pvalid = 0;
      end
      m_stall = (m_age == MAX);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_on) begin
      check("sector",       sector,       m_sector);
      check("sector_valid", sector_valid, m_valid);
      check("comm_stb",     comm_stb,     m_stb);
      check("dir",          dir,          m_dir);
      check("period",       period,       m_period);
      check("period_valid", period_valid, m_pvalid);
      check("seq_err",      seq_err,      m_seq);
      check("hall_fault",   hall_fault,   m_fault);
      check("stall",        stall,        m_stall);
      if (comm_stb) begin
        stb_seen++;
        if (seq_err) both_seen++;
        check("stb_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("stb_sector", sector, exp_q.pop_front());
      end
      if (seq_err) seq_seen++;
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [2:0] code, input int cycles);
    @(negedge clk);
    {h1, h2, h3} = code;
    repeat (cycles - 1) @(negedge clk);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin : stim
    logic [2:0] fwd[6];
    logic [2:0] rev[6];
    int s0, q0, b0, lat, n0;
    fwd = '{3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};
    rev = '{3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b100};

    rst = 1'b1;
    {h1, h2, h3} = 3'b100;
    repeat (3) @(negedge clk);
    check("rst_sector", sector, 0);
    check("rst_valid",  sector_valid, 0);
    check("rst_dir",    dir, 1);
    check("rst_fault",  hall_fault, 0);
    check("rst_stall",  stall, 0);
    rst = 1'b0;

    // Forward rotation
    s0 = stb_seen;
    drive(3'b100, 25);
    for (int i = 0; i < 6; i++) drive(fwd[i], 25);
    check("fwd_strobes", stb_seen - s0, 7);
    check("fwd_sector",  sector, 0);
    check("fwd_dir",     dir, 1);
    check("fwd_period",  period, 25);
    check("fwd_pvalid",  period_valid, 1);

    // Reverse rotation
    for (int i = 0; i < 6; i++) drive(rev[i], 25);
    check("rev_sector", sector, 0);
    check("rev_dir",    dir, 0);
    check("rev_period", period, 25);

    // Glitch rejection at sector 2, then latency of a real change
    drive(3'b101, 25);
    drive(3'b001, 25);
    check("glitch_pre_sector", sector, 2);
    s0 = stb_seen;
    drive(3'b011, 3);
    drive(3'b001, 20);
    check("glitch_strobes", stb_seen - s0, 0);
    check("glitch_sector",  sector, 2);
    @(negedge clk);
    {h1, h2, h3} = 3'b011;
    n0  = ecnt + 1;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (comm_stb) begin
        lat = ecnt - n0 + 1;
        break;
      end
    end
    check("latency_edges", lat, DEB + 3);
    check("latency_sector", sector, 3);
    repeat (15) @(negedge clk);

    // Fault and recovery
    drive(3'b001, 25);
    drive(3'b000, 25);
    check("fault_flag",   hall_fault, 1);
    check("fault_sector", sector, 2);
    s0 = stb_seen;
    drive(3'b001, 25);
    check("fault_clear",       hall_fault, 0);
    check("fault_same_strobe", stb_seen - s0, 0);
    check("fault_same_sector", sector, 2);
    s0 = stb_seen;
    drive(3'b011, 25);
    check("fault_next_sector", sector, 3);
    check("fault_next_strobe", stb_seen - s0, 1);

    // Jump and stall
    drive(3'b010, 25);
    drive(3'b110, 25);
    drive(3'b100, 25);
    q0 = seq_seen;
    b0 = both_seen;
    drive(3'b001, 25);
    check("jump_sector",  sector, 2);
    check("jump_seq",     seq_seen - q0, 1);
    check("jump_with_stb", both_seen - b0, 1);
    check("jump_pvalid",  period_valid, 0);
    drive(3'b001, 70);
    check("stall_set",    stall, 1);
    drive(3'b011, 25);
    check("stall_clear",  stall, 0);
    check("stall_pvalid", period_valid, 0);
    check("stall_sector", sector, 3);

    // Reset mid-rotation at sector 4
    drive(3'b010, 25);
    check("pre_rst_sector", sector, 4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_sector", sector, 0);
    check("mid_rst_valid",  sector_valid, 0);
    check("mid_rst_stb",    comm_stb, 0);
    check("mid_rst_dir",    dir, 1);
    check("mid_rst_period", period, 0);
    check("mid_rst_pvalid", period_valid, 0);
    check("mid_rst_seq",    seq_err, 0);
    check("mid_rst_fault",  hall_fault, 0);
    check("mid_rst_stall",  stall, 0);
    s0 = stb_seen;
    repeat (20) @(negedge clk);
    check("reacq_valid",  sector_valid, 1);
    check("reacq_sector", sector, 4);
    check("reacq_dir",    dir, 1);
    check("reacq_strobe", stb_seen - s0, 1);

    // Random hall codes with random hold times, including glitches and stalls
    for (int i = 0; i < 250; i++) begin
      logic [2:0] c;
      int len;
      c   = 3'($urandom_range(0, 7));
      len = ($urandom_range(0, 19) == 0) ? 70 : $urandom_range(1, 30);
      drive(c, len);
    end
    repeat (20) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
